// File: rtl/vga_fetch.sv
// vga_fetch: memory-side feeder for the VGA output stage.
// Each accepted vga_flag turns into one ZBT read of the displayed bank.
// The returned two-pixel word is held on vga_pixel with a done_vga pulse.
// The block also owns the display word counter and the display/write bank swap.
// Optional build feature: define VGA_FETCH_UNDERRUN_CNT_EN to build a
// saturating 16-bit dropped-request counter on underrun_cnt. When it is not
// defined, underrun_cnt reads as zero and no counter logic is built.
// Everything runs in the system clock domain with a synchronous reset.

module vga_fetch #(
  parameter int ADDR_W          = 19,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int WORDS_PER_FRAME = 153600,
  parameter int BANK0_BASE      = 0,
  parameter int BANK1_BASE      = 153600,
  parameter int MEM_LAT         = 2,
  parameter int LOG_HCOUNT      = 11,
  parameter int LOG_VCOUNT      = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vga_flag,
  input  logic [LOG_HCOUNT-1:0] hcount,
  input  logic [LOG_VCOUNT-1:0] vcount,
  input  logic                  frame_flag,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [35:0]           mem_rdata,
  output logic [35:0]           vga_pixel,
  output logic                  done_vga,
  output logic                  disp_bank,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  // Latency counter only has to hold MEM_LAT-1, so size it to that value.
  localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0]     BASE0     = ADDR_W'(BANK0_BASE);
  localparam logic [ADDR_W-1:0]     BASE1     = ADDR_W'(BANK1_BASE);
  localparam logic [ADDR_W-1:0]     WORD_LAST = ADDR_W'(WORDS_PER_FRAME - 1);
  localparam logic [LOG_HCOUNT-1:0] H_LIMIT   = LOG_HCOUNT'(H_ACTIVE);
  localparam logic [LOG_VCOUNT-1:0] V_LIMIT   = LOG_VCOUNT'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAP
  } state_t;

  state_t state;
  state_t state_next;

  logic              pending;
  logic              swap_pending;
  logic              vblank_d;
  logic [ADDR_W-1:0] word_cnt;
  logic [LAT_W-1:0]  lat_cnt;

  logic              visible;
  logic              vblank;
  logic              vblank_entry;
  logic              accept;
  logic              start_fetch;
  logic              grant_take;
  logic              drop;
  logic [ADDR_W-1:0] bank_base;

  // Request qualification and raster decode shared by the FSM and datapath.
  // A flag is only honoured inside the visible window; blanking flags vanish.
  assign visible      = (hcount < H_LIMIT) && (vcount < V_LIMIT);
  assign vblank       = (vcount >= V_LIMIT);
  assign vblank_entry = vblank && !vblank_d;
  assign accept       = vga_flag && visible;
  assign start_fetch  = (state == ST_IDLE) && (accept || pending);
  assign grant_take   = (state == ST_REQ) && mem_grant;
  assign drop         = accept && pending;
  assign bank_base    = disp_bank ? BASE1 : BASE0;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic: one read transaction per pass through the loop.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept || pending) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_grant) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == '0) begin
          state_next = ST_CAP;
        end
      end
      ST_CAP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: the request is held for the whole REQ state so the
  // arbiter sees a stable request until it grants.
  always_comb begin
    mem_req = (state == ST_REQ);
  end

  // Address latch: the bank and word are frozen at fetch start so a bank swap
  // that lands during REQ/WAIT cannot disturb the read already in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr <= '0;
    end else if (start_fetch) begin
      mem_addr <= bank_base + word_cnt;
    end
  end

  // Display word counter: advances on each grant, wraps at the frame size and
  // is held at zero throughout vertical blank so every frame restarts at word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (vblank) begin
      word_cnt <= '0;
    end else if (grant_take) begin
      if (word_cnt == WORD_LAST) begin
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Memory latency countdown between the grant and the capture cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (grant_take) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Pixel capture and completion pulse; data from a read cut off by reset
  // never reaches vga_pixel because reset returns the FSM to IDLE first.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_pixel <= '0;
      done_vga  <= 1'b0;
    end else begin
      done_vga <= (state == ST_CAP);
      if (state == ST_CAP) begin
        vga_pixel <= mem_rdata;
      end
    end
  end

  // One-deep request buffer: a flag arriving while busy waits here; a flag
  // arriving while it is already full is lost and flagged as an underrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (start_fetch) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending <= 1'b1;
    end
  end

  // Sticky underrun indicator, present in every build.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (drop) begin
      underrun <= 1'b1;
    end
  end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Saturating count of dropped requests, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun_cnt_q <= '0;
    end else if (drop && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  assign underrun_cnt = 16'h0000;
`endif

  // Vertical blank edge detector used to time the bank swap.
  always_ff @(posedge clock) begin
    if (reset) begin
      vblank_d <= 1'b0;
    end else begin
      vblank_d <= vblank;
    end
  end

  // Bank swap: any number of frame_flag pulses within a frame collapse into a
  // single toggle at the next vblank entry, including a pulse on that very cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (vblank_entry && (swap_pending || frame_flag)) begin
      disp_bank    <= ~disp_bank;
      swap_pending <= 1'b0;
    end else if (frame_flag) begin
      swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: self-checking bench for vga_fetch.
// A frame-level model tracks displayed bank and word position; expected
// addresses and pixel words are computed from that model.

module tb_vga_fetch;

  localparam int ADDR_W   = 19;
  localparam int V_ACTIVE = 480;
  localparam int WORDS    = 153600;
  localparam int BANK1    = 153600;

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  localparam int EXP_UC = 1;
`else
  localparam int EXP_UC = 0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              vga_flag;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic              frame_flag;
  logic              mem_req;
  logic              mem_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [35:0]       mem_rdata;
  logic [35:0]       vga_pixel;
  logic              done_vga;
  logic              disp_bank;
  logic              underrun;
  logic [15:0]       underrun_cnt;

  logic              withhold     = 1'b0;
  bit                rand_grant   = 1'b0;
  bit                use_fixed    = 1'b0;
  logic [35:0]       fixed_word   = 36'h0;
  logic [16:0]       salt         = 17'h0;
  logic [ADDR_W-1:0] granted_addr = '0;
  logic [ADDR_W-1:0] issued_q[$];

  int errors = 0;
  int checks = 0;

  bit model_bank = 1'b0;
  bit model_swap = 1'b0;
  int model_word = 0;

  vga_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .vga_flag     (vga_flag),
    .hcount       (hcount),
    .vcount       (vcount),
    .frame_flag   (frame_flag),
    .mem_req      (mem_req),
    .mem_grant    (mem_grant),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .vga_pixel    (vga_pixel),
    .done_vga     (done_vga),
    .disp_bank    (disp_bank),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clock = ~clock;

  // Arbiter/memory stand-in: grants unless withheld, returns a word tagged with
  // the granted address and holds it until the next grant.
  assign mem_grant = mem_req & ~withhold;
  assign mem_rdata = use_fixed ? fixed_word : {salt, granted_addr};

  always @(posedge clock) begin
    if (mem_req && mem_grant) begin
      granted_addr <= mem_addr;
      issued_q.push_back(mem_addr);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_grant) withhold = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] model_addr();
    int a;
    a = (model_bank ? BANK1 : 0) + model_word;
    return ADDR_W'(a);
  endfunction

  function automatic logic [35:0] model_data(input logic [ADDR_W-1:0] a);
    return use_fixed ? fixed_word : {salt, a};
  endfunction

  task automatic wait_done(input string tag, output bit seen);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((done_vga !== 1'b1) && (n < 60));
    seen = (done_vga === 1'b1);
    check({tag, "_done"}, 64'(seen), 64'd1);
  endtask

  task automatic finish_fetch(input string tag, input int idx, input logic [ADDR_W-1:0] ea);
    bit seen;
    logic [ADDR_W-1:0] got;
    wait_done(tag, seen);
    check({tag, "_pixel"}, 64'(vga_pixel), 64'(model_data(ea)));
    got = (issued_q.size() > idx) ? issued_q[idx] : 'x;
    check({tag, "_addr"}, 64'(got), 64'(ea));
  endtask

  task automatic fetch_one(input string tag, input logic [10:0] h, input logic [9:0] v);
    logic [ADDR_W-1:0] ea;
    int idx;
    ea  = model_addr();
    idx = issued_q.size();
    hcount   = h;
    vcount   = v;
    vga_flag = 1'b1;
    tick();
    vga_flag = 1'b0;
    finish_fetch(tag, idx, ea);
    model_word = (model_word + 1) % WORDS;
  endtask

  task automatic enter_vblank(input string tag, input bit ff);
    vcount     = 10'(V_ACTIVE);
    frame_flag = ff;
    tick();
    frame_flag = 1'b0;
    model_word = 0;
    if (model_swap || ff) begin
      model_bank = ~model_bank;
      model_swap = 1'b0;
    end
    check({tag, "_bank"}, 64'(disp_bank), 64'(model_bank));
    tick();
  endtask

  task automatic leave_vblank();
    vcount = 10'd0;
    tick();
  endtask

  task automatic pulse_frame(input logic [9:0] v);
    vcount     = v;
    frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
    model_swap = 1'b1;
  endtask

  task automatic model_reset();
    model_bank = 1'b0;
    model_swap = 1'b0;
    model_word = 0;
  endtask

  // Directed sequence followed by a randomized phase, all in one thread.
  initial begin
    int base_idx;
    bit seen;
    bit any_done;
    logic [ADDR_W-1:0] ea1;
    logic [ADDR_W-1:0] ea2;

    reset      = 1'b1;
    vga_flag   = 1'b0;
    hcount     = 11'd0;
    vcount     = 10'd0;
    frame_flag = 1'b0;
    tick();
    tick();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_vga_pixel", 64'(vga_pixel), 64'd0);
    check("rst_done_vga", 64'(done_vga), 64'd0);
    check("rst_disp_bank", 64'(disp_bank), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_underrun_cnt", 64'(underrun_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // First fetch with an always-granting arbiter: exact latency.
    use_fixed  = 1'b1;
    fixed_word = 36'h123456789;
    hcount   = 11'd0;
    vcount   = 10'd0;
    vga_flag = 1'b1;
    tick();
    vga_flag = 1'b0;
    check("t1_req", 64'(mem_req), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'd0);
    tick();
    tick();
    tick();
    check("t1_early", 64'(done_vga), 64'd0);
    tick();
    check("t1_done", 64'(done_vga), 64'd1);
    check("t1_pixel", 64'(vga_pixel), 64'h123456789);
    tick();
    check("t1_pulse", 64'(done_vga), 64'd0);
    model_word = 1;
    use_fixed  = 1'b0;

    // A full visible line of words, then blanking flags, then line 1.
    enter_vblank("t2_vb", 1'b0);
    leave_vblank();
    rand_grant = 1'b1;
    salt = 17'($urandom);
    for (int i = 0; i < 320; i++) begin
      fetch_one($sformatf("t2_w%0d", i), 11'(2 * i), 10'd0);
    end
    base_idx = issued_q.size();
    for (int k = 0; k < 5; k++) begin
      hcount   = 11'(640 + $urandom_range(0, 159));
      vcount   = 10'd0;
      vga_flag = 1'b1;
      tick();
      vga_flag = 1'b0;
      check($sformatf("t2_blank_req%0d", k), 64'(mem_req), 64'd0);
      tick();
    end
    check("t2_blank_issued", 64'(issued_q.size()), 64'(base_idx));
    check("t2_blank_underrun", 64'(underrun), 64'd0);
    fetch_one("t2_line1", 11'd0, 10'd1);
    check("t2_line1_lit", 64'(issued_q[issued_q.size() - 1]), 64'd320);

    // Withheld grant: stable request, one pending flag, one dropped flag.
    rand_grant = 1'b0;
    withhold   = 1'b1;
    salt       = 17'($urandom);
    ea1        = model_addr();
    base_idx   = issued_q.size();
    hcount     = 11'd100;
    vcount     = 10'd2;
    vga_flag   = 1'b1;
    tick();
    vga_flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_req%0d", i), 64'(mem_req), 64'd1);
      check($sformatf("t3_addr%0d", i), 64'(mem_addr), 64'(ea1));
      vga_flag = (i == 2) || (i == 5);
      tick();
      vga_flag = 1'b0;
    end
    check("t3_underrun", 64'(underrun), 64'd1);
    check("t3_underrun_cnt", 64'(underrun_cnt), 64'(EXP_UC));
    withhold = 1'b0;
    finish_fetch("t3_first", base_idx, ea1);
    model_word = model_word + 1;
    ea2 = model_addr();
    finish_fetch("t3_pending", base_idx + 1, ea2);
    model_word = model_word + 1;
    for (int i = 0; i < 10; i++) tick();
    check("t3_no_third", 64'(issued_q.size()), 64'(base_idx + 2));
    check("t3_sticky", 64'(underrun), 64'd1);

    // Two frame_flag pulses in one frame give one swap at vblank entry.
    pulse_frame(10'd5);
    tick();
    pulse_frame(10'd7);
    check("t4_hold", 64'(disp_bank), 64'(model_bank));
    enter_vblank("t4_vb", 1'b0);
    leave_vblank();
    fetch_one("t4_first", 11'd0, 10'd0);
    check("t4_addr_lit", 64'(issued_q[issued_q.size() - 1]), 64'd153600);
    enter_vblank("t4_single", 1'b0);
    leave_vblank();

    // frame_flag on the vblank-entry cycle swaps at once and leaves nothing behind.
    enter_vblank("t5_coinc", 1'b1);
    leave_vblank();
    enter_vblank("t5_clear", 1'b0);
    leave_vblank();

    // Reset while a read is in WAIT on bank 1.
    pulse_frame(10'd3);
    enter_vblank("t6_vb", 1'b0);
    leave_vblank();
    fetch_one("t6_pre", 11'd0, 10'd0);
    hcount   = 11'd2;
    vcount   = 10'd0;
    vga_flag = 1'b1;
    tick();
    vga_flag = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("t6_req_after_rst", 64'(mem_req), 64'd0);
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_vga === 1'b1) any_done = 1'b1;
    end
    check("t6_no_done", 64'(any_done), 64'd0);
    check("t6_bank", 64'(disp_bank), 64'd0);
    issued_q.delete();
    fetch_one("t6_after", 11'd0, 10'd0);

    // Reset while the request is still waiting for a grant.
    withhold = 1'b1;
    hcount   = 11'd4;
    vga_flag = 1'b1;
    tick();
    vga_flag = 1'b0;
    check("t6_req_up", 64'(mem_req), 64'd1);
    reset = 1'b1;
    tick();
    check("t6_req_drop", 64'(mem_req), 64'd0);
    reset    = 1'b0;
    withhold = 1'b0;
    model_reset();
    tick();
    fetch_one("t6_req_after", 11'd0, 10'd0);

    // Randomized phase: random positions, gaps, grant stalls and frame events.
    rand_grant = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int r;
      salt = 17'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pulse_frame(10'($urandom_range(0, 479)));
      end else if (r == 1) begin
        enter_vblank($sformatf("rnd_vb%0d", i), 1'($urandom_range(0, 1)));
        leave_vblank();
      end else begin
        fetch_one($sformatf("rnd_f%0d", i), 11'($urandom_range(0, 639)),
                  10'($urandom_range(0, 479)));
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    rand_grant = 1'b0;
    withhold   = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_fetch.md
Name: vga_fetch

Overview:
- Memory-side feeder for the VGA output stage.
- Turns each `vga_flag` word request into a ZBT read of the display bank.
- Returns the 36-bit two-pixel word on `vga_pixel`, with a one-cycle `done_vga` pulse.
- Owns the display word counter and display/write bank swap; runs entirely in the system clock domain.

Parameters:
- ADDR_W, 19, ZBT word address width
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- WORDS_PER_FRAME, 153600, H_ACTIVE*V_ACTIVE/2 (two pixels per word)
- BANK0_BASE, 0, word base of display bank 0
- BANK1_BASE, 153600, word base of display bank 1
- MEM_LAT, 2, cycles from mem_grant to valid mem_rdata

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- vga_flag  in  1  one-cycle request for the next word, from the VGA stage
- hcount  in  LOG_HCOUNT  VGA pixel counter, synchronised to clock
- vcount  in  LOG_VCOUNT  VGA line counter, synchronised to clock
- frame_flag  in  1  pulse: writer has completed a frame in the non-displayed bank
- mem_req  out  1  read request to the memory arbiter
- mem_grant  in  1  arbiter accepts mem_req/mem_addr this cycle
- mem_addr  out  ADDR_W  read word address
- mem_rdata  in  36  ZBT read data
- vga_pixel  out  36  held pixel pair {Y0[35:28],Cr0,Cb0,Y1[17:10],Cr1,Cb1}
- done_vga  out  1  one-cycle pulse: vga_pixel updated
- disp_bank  out  1  bank currently displayed
- underrun  out  1  sticky: a request was dropped
- underrun_cnt  out  16  dropped-request count (optional feature)

Behaviour:
- Reset values: mem_req=0, mem_addr=0, vga_pixel=0, done_vga=0, disp_bank=0, underrun=0, underrun_cnt=0. Internal state: word_cnt=0, swap_pending=0, pending=0, FSM=IDLE.
- Reset mid-transaction: mem_req drops next edge; any in-flight read data is discarded.
- Visible gating: a vga_flag is accepted only when hcount<H_ACTIVE and vcount<V_ACTIVE. Flags during blanking are ignored and do not count as underruns.
- Accepted flag handling:
  - FSM in IDLE and pending=0: start a fetch.
  - Otherwise: set pending.
  - If pending is already 1: drop the flag, set underrun, increment underrun_cnt.
- FSM:
  - IDLE: if an accepted flag or pending is present, latch mem_addr = (disp_bank ? BANK1_BASE : BANK0_BASE) + word_cnt, assert mem_req, clear pending, go REQ.
  - REQ: hold mem_req and mem_addr stable until mem_grant. On the grant cycle, deassert mem_req next edge, increment word_cnt, load the latency counter with MEM_LAT-1, go WAIT.
  - WAIT: count down. At 0, go CAP.
  - CAP: vga_pixel <= mem_rdata, done_vga=1 for exactly this cycle, go IDLE.
- Latency: minimum flag-to-done_vga is 2+MEM_LAT+1 cycles with immediate grant (5 at default).
- word_cnt wrap: increments modulo WORDS_PER_FRAME. It is forced to 0 on every cycle where vcount>=V_ACTIVE (vertical blank), which resynchronises each frame.
- Bank swap:
  - frame_flag sets swap_pending.
  - On the first cycle with vcount>=V_ACTIVE after vcount<V_ACTIVE, if swap_pending (or frame_flag is high that same cycle): toggle disp_bank and clear swap_pending.
  - A fetch in REQ/WAIT at the swap point completes with its already-latched address.
- Multiple frame_flag pulses before a swap produce one swap.
- mem_addr arithmetic is ADDR_W wide; the sum is truncated with no carry-out.

Optional Feature:
- Macro: VGA_FETCH_UNDERRUN_CNT_EN.
- Defined: underrun_cnt is a 16-bit counter, saturating at 16'hFFFF, cleared only by reset.
- Undefined: underrun_cnt is tied to 0 and no counter logic is built. The sticky underrun bit exists in both builds.

Test Plan:
- Reset, then one vga_flag at hcount=0, vcount=0 with mem_grant tied 1 and mem_rdata=36'h123456789 -> mem_addr=0, done_vga pulses 5 cycles after the flag, vga_pixel=36'h123456789.
- 320 flags across visible line 0, then line 1 start -> addresses 0..319, and the first address on line 1 is 320. Flags at hcount 640..799 issue no mem_req.
- mem_grant withheld 10 cycles -> mem_req/mem_addr stable throughout. A second flag is held pending and served next. A third flag sets underrun=1 and underrun_cnt=1 (macro defined) or 0 (undefined).
- frame_flag pulse mid-frame -> disp_bank toggles at vcount=480 entry. First fetch of the next frame uses address 153600. A second frame_flag in the same frame still produces a single toggle.
- frame_flag coincident with the vblank-entry cycle -> swap happens that frame and swap_pending=0 afterwards.
- Assert reset while in WAIT -> mem_req=0 and done_vga never pulses for that fetch. After release, the next flag fetches address 0 on bank 0.
